// File: rtl/log_encoder_seq_if.sv
// log_encoder_seq_if: operand-in / log-fields-out handshake bundle for the log encoder
interface log_encoder_seq_if #(
  parameter int WIDTH = 16
);
  localparam int KW = $clog2(WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [KW-1:0]    out_k;
  logic [WIDTH-2:0] out_frac;
  logic             out_zero;
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_k, out_frac, out_zero
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_k, out_frac, out_zero
  );
endinterface

// File: rtl/log_encoder_seq.sv
// log_encoder_seq: binary-search leading-one normaliser producing characteristic k and fraction
module log_encoder_seq #(
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  log_encoder_seq_if.slave bus
);
  localparam int KW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NORM = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] r, r_nx;
  logic [KW-1:0]    k, k_nx, step, sh;
  logic             top_zero;
  assign bus.in_ready = state == IDLE;
  // one search stage: shift the operand up by the stage size when its top slice is empty
  always_comb begin
    sh = KW'(WIDTH >> (32'(step) + 1));
    top_zero = (r >> (WIDTH - 32'(sh))) == '0;
    r_nx = top_zero ? r << sh : r;
    k_nx = top_zero ? k - sh : k;
  end
  // handshake FSM: accept operand, run KW stages, hold result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      r             <= '0;
      k             <= '0;
      step          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_k     <= '0;
      bus.out_frac  <= '0;
      bus.out_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          r             <= bus.in_data;
          k             <= KW'(WIDTH - 1);
          step          <= '0;
          bus.out_zero  <= bus.in_data == '0;
          bus.out_valid <= 1'b0;
          state         <= NORM;
        end
        NORM: begin
          r    <= r_nx;
          k    <= k_nx;
          step <= step + 1'b1;
          if (step == KW'(KW - 1)) begin
            bus.out_k     <= k_nx;
            bus.out_frac  <= r_nx[WIDTH-2:0];
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_log_encoder_seq.sv
// tb_log_encoder_seq: directed vectors plus random leading-one model scoreboard
module tb_log_encoder_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  log_encoder_seq_if #(.WIDTH(16)) bus ();
  log_encoder_seq #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [19:0] model(input logic [15:0] n);
    logic [3:0]  kk = 4'd0;
    logic [15:0] s;
    for (int i = 0; i < 16; i++) if (n[i]) kk = 4'(i);
    s = n << (4'd15 - kk);
    return {n == 16'h0, kk, s[14:0]};
  endfunction
  task automatic xfer(input logic [15:0] d, output logic [19:0] res, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    if (lat >= 20) check("timeout", 32'(lat), 32'd4);
    res = {bus.out_zero, bus.out_k, bus.out_frac};
    @(posedge clk);
    #1;
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [19:0] res;
    logic [19:0] held;
    logic [15:0] n;
    int lat;
    int seen;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_state", {bus.in_ready, bus.out_valid, bus.out_zero, bus.out_k, bus.out_frac},
          {1'b1, 1'b0, 20'h0});
    // T1..T4 directed
    xfer(16'h0001, res, lat);
    check("t1_lat", 32'(lat), 32'd4);
    check("t1_res", res, {1'b0, 4'd0, 15'h0000});
    xfer(16'h8000, res, lat);
    check("t2_8000", res, {1'b0, 4'd15, 15'h0000});
    xfer(16'hFFFF, res, lat);
    check("t2_ffff", res, {1'b0, 4'd15, 15'h7FFF});
    xfer(16'h00B4, res, lat);
    check("t3_00b4", res, {1'b0, 4'd7, 15'h3400});
    xfer(16'h0003, res, lat);
    check("t3_0003", res, {1'b0, 4'd1, 15'h4000});
    xfer(16'h0000, res, lat);
    check("t4_lat", 32'(lat), 32'd4);
    check("t4_zero", res, {1'b1, 4'd0, 15'h0000});
    // T5 backpressure with ignored in_valid pulses
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h00B4;
    @(posedge clk);
    #1 bus.in_data = 16'h1234;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check("t5_lat", 32'(lat), 32'd4);
    held = {bus.out_zero, bus.out_k, bus.out_frac};
    check("t5_res", held, {1'b0, 4'd7, 15'h3400});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = i[0];
      @(posedge clk);
      #1 check("t5_hold", {bus.in_ready, bus.out_valid, bus.out_zero, bus.out_k, bus.out_frac},
               {1'b0, 1'b1, held});
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 check("t5_idle", {bus.in_ready, bus.out_valid}, 2'b10);
    xfer(16'h1234, res, lat);
    check("t5_1234", res, {1'b0, 4'd12, 15'h11A0});
    // T6 reset mid-NORM
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0000;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("t6_reset", {bus.in_ready, bus.out_valid, bus.out_zero, bus.out_k, bus.out_frac},
          {1'b1, 1'b0, 20'h0});
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1 if (bus.out_valid) seen++;
    end
    check("t6_no_stale", 32'(seen), 32'd0);
    xfer(16'h0100, res, lat);
    check("t6_0100", res, {1'b0, 4'd8, 15'h0000});
    // random scoreboard
    for (int i = 0; i < 10000; i++) begin
      n = 16'($urandom);
      if (i % 97 == 0) n = 16'h1 << (i % 16);
      xfer(n, res, lat);
      check("rand", res, model(n));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
